// File: rtl/mix_pkg.sv
// Shared constants and helpers for the MIX byte-shift execution unit.
package mix_pkg;

    localparam int BYTE_W = 6;
    localparam int NBYTES = 5;
    localparam int WORD_W = 30;
    localparam int AX_W   = 2 * WORD_W;

    localparam logic [5:0] F_SLA  = 6'd0;
    localparam logic [5:0] F_SRA  = 6'd1;
    localparam logic [5:0] F_SLAX = 6'd2;
    localparam logic [5:0] F_SRAX = 6'd3;
    localparam logic [5:0] F_SLC  = 6'd4;
    localparam logic [5:0] F_SRC  = 6'd5;

    // Full-range reduction of the 12-bit count for the rotates.
    function automatic logic [3:0] mod10(input logic [11:0] v);
        logic [11:0] r;
        r = v % 12'd10;
        return r[3:0];
    endfunction

endpackage

// File: rtl/mix_byte_shifter.sv
// Combinational 10-byte shifter/rotator; count is in bytes (0..10).
module mix_byte_shifter
    import mix_pkg::*;
(
    input  logic [AX_W-1:0] data,
    input  logic [3:0]      count,
    input  logic            right,
    input  logic            rotate,
    output logic [AX_W-1:0] result
);

    logic [6:0]      amt;
    logic [6:0]      back;
    logic [AX_W-1:0] main_part;
    logic [AX_W-1:0] wrap_part;

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        amt  = 7'(count) * 7'(BYTE_W);
        back = 7'(AX_W) - amt;
        if (right) begin
            main_part = data >> amt;
            wrap_part = data << back;
        end else begin
            main_part = data << amt;
            wrap_part = data >> back;
        end
        // A shift by the full width yields zero, so count 0 and count 10 need no special case.
        result = rotate ? (main_part | wrap_part) : main_part;
    end

endmodule

// File: rtl/mix_shift.sv
// MIX SLA/SRA/SLAX/SRAX/SLC/SRC unit: registered result one cycle after start.
module mix_shift
    import mix_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] ina,
    input  logic [WORD_W-1:0] inx,
    input  logic [5:0]        field,
    input  logic [11:0]       m,
    output logic [AX_W-1:0]   out,
    output logic              done
);

    logic [3:0]      sat_cnt;
    logic [3:0]      rot_cnt;
    logic [AX_W-1:0] sh_data;
    logic [3:0]      sh_count;
    logic            sh_right;
    logic            sh_rot;
    logic            a_only;
    logic [AX_W-1:0] sh_out;
    logic [AX_W-1:0] nxt;

    always_comb begin
        sat_cnt  = (m >= 12'd10) ? 4'd10 : m[3:0];
        rot_cnt  = mod10(m);
        sh_data  = {ina, inx};
        sh_count = 4'd0;
        sh_right = 1'b0;
        sh_rot   = 1'b0;
        a_only   = 1'b0;
        // A-only shifts run A through the wide shifter with a zero lower half as fill.
        case (field)
            F_SLA: begin
                sh_data  = {ina, {WORD_W{1'b0}}};
                sh_count = sat_cnt;
                a_only   = 1'b1;
            end
            F_SRA: begin
                sh_data  = {ina, {WORD_W{1'b0}}};
                sh_count = sat_cnt;
                sh_right = 1'b1;
                a_only   = 1'b1;
            end
            F_SLAX: sh_count = sat_cnt;
            F_SRAX: begin
                sh_count = sat_cnt;
                sh_right = 1'b1;
            end
            F_SLC: begin
                sh_count = rot_cnt;
                sh_rot   = 1'b1;
            end
            F_SRC: begin
                sh_count = rot_cnt;
                sh_rot   = 1'b1;
                sh_right = 1'b1;
            end
            default: ;
        endcase
    end

    mix_byte_shifter u_shifter (
        .data   (sh_data),
        .count  (sh_count),
        .right  (sh_right),
        .rotate (sh_rot),
        .result (sh_out)
    );

    assign nxt = a_only ? {sh_out[AX_W-1:WORD_W], inx} : sh_out;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            out  <= '0;
            done <= 1'b0;
        end else begin
            done <= start;
            if (start) out <= nxt;
        end
    end

endmodule

// File: tb/tb_mix_shift.sv
// Self-checking bench for mix_shift: directed cases plus random stimulus against a byte-array model.
module tb_mix_shift;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [29:0] ina;
    logic [29:0] inx;
    logic [5:0]  field;
    logic [11:0] m;
    logic [59:0] out;
    logic        done;

    int n_asserts = 0;
    int n_fail    = 0;

    mix_shift dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ina   (ina),
        .inx   (inx),
        .field (field),
        .m     (m),
        .out   (out),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] pk5(input int b1, input int b2, input int b3, input int b4, input int b5);
        logic [5:0] v1, v2, v3, v4, v5;
        v1 = 6'(b1); v2 = 6'(b2); v3 = 6'(b3); v4 = 6'(b4); v5 = 6'(b5);
        return {v1, v2, v3, v4, v5};
    endfunction

    // Reference: operate on an array of ten bytes, index 0 = byte1 of rA.
    function automatic logic [59:0] model(input logic [5:0] f, input logic [11:0] mm,
                                          input logic [29:0] a, input logic [29:0] x);
        int b[10];
        int r[10];
        int n;
        int src;
        logic [59:0] ax;
        logic [59:0] res;
        ax = {a, x};
        n  = int'(mm);
        for (int k = 0; k < 10; k++) b[k] = int'(ax[59-6*k -: 6]);
        for (int k = 0; k < 10; k++) r[k] = b[k];
        case (f)
            6'd0: for (int k = 0; k < 5; k++) begin src = k + n; r[k] = (src < 5) ? b[src] : 0; end
            6'd1: for (int k = 0; k < 5; k++) begin src = k - n; r[k] = (src >= 0) ? b[src] : 0; end
            6'd2: for (int k = 0; k < 10; k++) begin src = k + n; r[k] = (src < 10) ? b[src] : 0; end
            6'd3: for (int k = 0; k < 10; k++) begin src = k - n; r[k] = (src >= 0) ? b[src] : 0; end
            6'd4: for (int k = 0; k < 10; k++) r[k] = b[(k + n) % 10];
            6'd5: for (int k = 0; k < 10; k++) r[k] = b[(k - (n % 10) + 10) % 10];
            default: ;
        endcase
        res = '0;
        for (int k = 0; k < 10; k++) res[59-6*k -: 6] = 6'(r[k]);
        return res;
    endfunction

    task automatic check(input string tag, input logic [59:0] obs, input logic [59:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One start pulse; returns just after the capturing edge with start lowered.
    task automatic do_op(input logic [5:0] f, input logic [11:0] mm, input logic [29:0] a, input logic [29:0] x);
        @(negedge clk);
        start = 1'b1; field = f; m = mm; ina = a; inx = x;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    logic [29:0] ta, tx, ra, rx;
    logic [5:0]  rf;
    logic [11:0] rm;
    logic [59:0] hold;

    initial begin
        reset = 1'b1; start = 1'b0; ina = '0; inx = '0; field = '0; m = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", out, 60'd0);
        check("reset_done", {59'd0, done}, 60'd1 - 60'd1);
        @(negedge clk);
        reset = 1'b0;

        ta = 30'd792348734;
        tx = 30'd234234234;
        check("a_bytes", {30'd0, ta}, {30'd0, pk5(47, 14, 36, 32, 62)});
        check("x_bytes", {30'd0, tx}, {30'd0, pk5(13, 61, 34, 5, 58)});

        do_op(6'd4, 12'd1, ta, tx);
        check("slc1_done", {59'd0, done}, 60'd1);
        check("slc1", out, {pk5(14, 36, 32, 62, 13), pk5(61, 34, 5, 58, 47)});
        @(posedge clk); #1;
        check("done_drops", {59'd0, done}, 60'd0);

        do_op(6'd0, 12'd2, ta, tx);
        check("sla2", out, {pk5(36, 32, 62, 0, 0), tx});
        do_op(6'd0, 12'd5, ta, tx);
        check("sla5", out, {30'd0, tx});
        do_op(6'd0, 12'd4095, ta, tx);
        check("sla4095", out, {30'd0, tx});
        do_op(6'd3, 12'd3, ta, tx);
        check("srax3", out, {pk5(0, 0, 0, 47, 14), pk5(36, 32, 62, 13, 61)});
        do_op(6'd3, 12'd10, ta, tx);
        check("srax10", out, 60'd0);
        do_op(6'd5, 12'd10, ta, tx);
        check("src10", out, {ta, tx});
        do_op(6'd5, 12'd11, ta, tx);
        check("src11", out, {pk5(58, 47, 14, 36, 32), pk5(62, 13, 61, 34, 5)});
        do_op(6'd1, 12'd0, ta, tx);
        check("sra0", out, {ta, tx});

        // Inputs changing while start is low must not disturb the held result.
        hold = out;
        @(negedge clk);
        ina = 30'h3FFF_FFFF; inx = 30'h1234567; field = 6'd2; m = 12'd1;
        @(posedge clk); #1;
        check("hold_out", out, hold);

        for (int i = 0; i < 60; i++) begin
            ra = 30'($urandom);
            rx = 30'($urandom);
            rf = 6'($urandom_range(0, 7));
            rm = (i % 3 == 0) ? 12'($urandom) : 12'($urandom_range(0, 12));
            do_op(rf, rm, ra, rx);
            check($sformatf("rand%0d_f%0d_m%0d", i, rf, rm), out, model(rf, rm, ra, rx));
        end

        // Back-to-back rotates: start held high, one new request per cycle.
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b1; field = 6'd4; m = 12'(i); ina = ta; inx = tx;
            @(posedge clk); #1;
            check($sformatf("b2b_out%0d", i), out, model(6'd4, 12'(i), ta, tx));
            check($sformatf("b2b_done%0d", i), {59'd0, done}, 60'd1);
        end
        @(negedge clk);
        start = 1'b0;

        do_op(6'd9, 12'd3, ta, tx);
        check("field9", out, {ta, tx});
        check("field9_done", {59'd0, done}, 60'd1);

        @(negedge clk);
        start = 1'b1; reset = 1'b1; field = 6'd4; m = 12'd1; ina = ta; inx = tx;
        @(posedge clk); #1;
        check("rst_start_out", out, 60'd0);
        check("rst_start_done", {59'd0, done}, 60'd0);
        start = 1'b0; reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
